link_rx: RTL and testbench
==========================

LINK_RX -- requirements
Module: link_rx

Interface
- REQ-001 Parameter: STABLE_CYCLES, default 16, meaning consecutive clock cycles a synchronized input must hold before it is accepted.
- REQ-002 Parameter: QUAL_TIMEOUT, default 1024, meaning maximum cycles in QUAL before an error is declared.
- REQ-003 Port: clk, input, 1, system clock (60 MHz domain).
- REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
- REQ-005 Port: in_player1_ready, input, 1, asynchronous level from remote board.
- REQ-006 Port: in_player2_ready, input, 1, asynchronous level from remote board.
- REQ-007 Port: in_power, input, 5, asynchronous throw power from remote board.
- REQ-008 Port: in_throw_flag, input, 1, asynchronous throw request from remote board.
- REQ-009 Port: player1_ready, output, 1, filtered remote player-1 ready level.
- REQ-010 Port: player2_ready, output, 1, filtered remote player-2 ready level.
- REQ-011 Port: throw_valid, output, 1, one-cycle pulse when a throw is accepted.
- REQ-012 Port: throw_power, output, 5, power captured with the last accepted throw.
- REQ-013 Port: link_error, output, 1, sticky flag for a qualification timeout.

Function
- REQ-014 Every input bit SHALL pass through a 2-flop synchronizer before any other use.
- REQ-015 Each ready output SHALL change only after the synchronized input holds its new value for STABLE_CYCLES consecutive cycles, with any toggle restarting the count.
- REQ-016 The FSM SHALL have states IDLE, QUAL, DONE.
- REQ-017 IDLE→QUAL SHALL occur on a synchronized throw_flag rising edge, clearing the stability counter and latching the synchronized power.
- REQ-018 In QUAL, a change of synchronized power SHALL re-latch the power and restart the counter.
- REQ-019 In QUAL, flag low before the count completes SHALL return to IDLE with no pulse (glitch reject).
- REQ-020 QUAL→DONE SHALL occur when flag and power are both stable for STABLE_CYCLES cycles.
- REQ-021 On QUAL→DONE, throw_power SHALL load the latched power and throw_valid SHALL be 1 for exactly one cycle.
- REQ-022 On entry to DONE, throw_valid SHALL have a latency of STABLE_CYCLES+2 cycles from the raw flag edge (synchronizer included).
- REQ-023 DONE→IDLE SHALL occur only after synchronized flag is low for STABLE_CYCLES cycles; a held-high flag SHALL never produce a second pulse.
- REQ-024 If QUAL persists QUAL_TIMEOUT cycles, the FSM SHALL set link_error and return to IDLE.
- REQ-025 link_error SHALL clear only on reset.
- REQ-026 throw_power SHALL hold its value between accepted throws, and power value 0 SHALL be accepted as legal.
- REQ-027 Counters SHALL saturate and never wrap, sized $clog2 of their limit +1.

Reset
- REQ-028 On rst_n low, all of the following SHALL be 0: synchronizers, counters, player1_ready, player2_ready, throw_valid, throw_power, link_error.
- REQ-029 On rst_n low, the FSM SHALL be forced to IDLE.
- REQ-030 Reset asserted mid-QUAL or mid-DONE SHALL abort without a pulse.
- REQ-031 After release, a flag already high SHALL not count as a rising edge until seen low.

Structure
- REQ-032 The state enum (IDLE, QUAL, DONE) and the power width constant (5) SHALL live in the shared game package.
- REQ-033 One sub-module, link_filter (synchronizer plus stability counter, parameterized width), SHALL be instantiated for each ready line.

Verification
- REQ-034 Power=5'd19 set, flag raised and held 40 cycles → exactly one throw_valid at edge+18, throw_power=19.
- REQ-035 Flag pulse of 5 cycles → no throw_valid, FSM back in IDLE.
- REQ-036 Flag high with power toggling 3↔4 every 8 cycles for 1100 cycles → link_error=1, no throw_valid.
- REQ-037 in_player1_ready glitch of 3 cycles → player1_ready stays 0; held high 20 cycles → player1_ready=1 at cycle 18.
- REQ-038 rst_n pulsed low during QUAL with flag still high → all outputs 0, no pulse until the flag goes low then high again.

Source files
------------

// File: rtl/link_rx_pkg.sv
// Shared game package: link receiver state encoding and throw power width.
package link_rx_pkg;

    localparam int POWER_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        DONE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/link_filter.sv
// Two-flop synchronizer followed by a stability filter.
// The output follows the synchronized input only after it has held one new
// value for STABLE_CYCLES consecutive cycles; any change restarts the count.
module link_filter #(
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] held;
    logic [CW-1:0]    cnt;

    // Synchronize, then count how long a new value has held before accepting it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            held  <= '0;
            cnt   <= '0;
            dout  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            held  <= sync2;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (sync2 != held) begin
                cnt <= CW'(1);
            end else if (cnt >= CNT_LAST) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/link_rx.sv
// Remote board link receiver: filters the two ready lines and qualifies
// throw requests (flag + power) before issuing a single throw_valid pulse.
module link_rx
    import link_rx_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int QUAL_TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_player1_ready,
    input  logic               in_player2_ready,
    input  logic [POWER_W-1:0] in_power,
    input  logic               in_throw_flag,
    output logic               player1_ready,
    output logic               player2_ready,
    output logic               throw_valid,
    output logic [POWER_W-1:0] throw_power,
    output logic               link_error
);

    localparam int             SCW        = $clog2(STABLE_CYCLES + 1);
    localparam int             TCW        = $clog2(QUAL_TIMEOUT + 1);
    // The rising-edge cycle and the QUAL entry cycle already saw the flag high,
    // so QUAL only needs STABLE_CYCLES-2 further stable cycles.
    localparam logic [SCW-1:0] QUAL_LAST  = SCW'(STABLE_CYCLES - 2);
    localparam logic [SCW-1:0] DONE_LAST  = SCW'(STABLE_CYCLES - 1);
    localparam logic [TCW-1:0] TIMER_LAST = TCW'(QUAL_TIMEOUT - 1);

    logic               flag_s1;
    logic               flag_s;
    logic [POWER_W-1:0] power_s1;
    logic [POWER_W-1:0] power_s;
    logic [1:0]         settle;
    logic               armed;
    rx_state_t          state;
    logic [SCW-1:0]     cnt;
    logic [TCW-1:0]     timer;
    logic [POWER_W-1:0] power_lat;

    link_filter #(
        .WIDTH         (1),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_player1_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in_player1_ready),
        .dout  (player1_ready)
    );

    link_filter #(
        .WIDTH         (1),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_player2_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in_player2_ready),
        .dout  (player2_ready)
    );

    // Two-flop synchronizers for the throw flag and power bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_s1  <= 1'b0;
            flag_s   <= 1'b0;
            power_s1 <= '0;
            power_s  <= '0;
        end else begin
            flag_s1  <= in_throw_flag;
            flag_s   <= flag_s1;
            power_s1 <= in_power;
            power_s  <= power_s1;
        end
    end

    // Throw qualification FSM; armed means the flag has been seen low since
    // the synchronizer settled, so a flag already high after reset is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle      <= 2'b00;
            armed       <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            timer       <= '0;
            power_lat   <= '0;
            throw_valid <= 1'b0;
            throw_power <= '0;
            link_error  <= 1'b0;
        end else begin
            settle      <= {settle[0], 1'b1};
            throw_valid <= 1'b0;

            if (state == IDLE && armed && flag_s) begin
                armed <= 1'b0;
            end else if (settle[1] && !flag_s) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    cnt   <= '0;
                    timer <= '0;
                    if (armed && flag_s) begin
                        state     <= QUAL;
                        power_lat <= power_s;
                    end
                end
                QUAL: begin
                    if (!flag_s) begin
                        state <= IDLE;
                    end else if (timer >= TIMER_LAST) begin
                        link_error <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (power_s != power_lat) begin
                            power_lat <= power_s;
                            cnt       <= '0;
                        end else if (cnt >= QUAL_LAST) begin
                            state       <= DONE;
                            throw_power <= power_lat;
                            throw_valid <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (flag_s) begin
                        cnt <= '0;
                    end else if (cnt >= DONE_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_rx.sv
// Directed testbench for link_rx: throw qualification, glitch reject,
// qualification timeout, ready filtering and reset abort.
module tb_link_rx;
    import link_rx_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               in_player1_ready;
    logic               in_player2_ready;
    logic [POWER_W-1:0] in_power;
    logic               in_throw_flag;
    logic               player1_ready;
    logic               player2_ready;
    logic               throw_valid;
    logic [POWER_W-1:0] throw_power;
    logic               link_error;

    int n_checks;
    int n_errors;
    int first_pulse;
    int pulse_count;
    int first_r1;
    int first_r2;
    int total_pulses;

    link_rx #(
        .STABLE_CYCLES (16),
        .QUAL_TIMEOUT  (1024)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_player1_ready (in_player1_ready),
        .in_player2_ready (in_player2_ready),
        .in_power         (in_power),
        .in_throw_flag    (in_throw_flag),
        .player1_ready    (player1_ready),
        .player2_ready    (player2_ready),
        .throw_valid      (throw_valid),
        .throw_power      (throw_power),
        .link_error       (link_error)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive inputs just after an edge (edge 0), then sample n edges, noting
    // the first edge index at which each watched output is high
    task automatic applyStimulus(input logic flag, input logic [POWER_W-1:0] power,
                                 input logic r1, input logic r2, input int n);
        first_pulse = -1;
        pulse_count = 0;
        first_r1    = -1;
        first_r2    = -1;
        @(posedge clk);
        #1;
        in_throw_flag    = flag;
        in_power         = power;
        in_player1_ready = r1;
        in_player2_ready = r2;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #2;
            if (throw_valid === 1'b1) begin
                pulse_count++;
                if (first_pulse < 0) first_pulse = k;
            end
            if (player1_ready === 1'b1 && first_r1 < 0) first_r1 = k;
            if (player2_ready === 1'b1 && first_r2 < 0) first_r2 = k;
        end
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        total_pulses     = 0;
        rst_n            = 1'b0;
        in_player1_ready = 1'b0;
        in_player2_ready = 1'b0;
        in_power         = '0;
        in_throw_flag    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_p1", int'(player1_ready), 0);
        checkOutput("rst_p2", int'(player2_ready), 0);
        checkOutput("rst_valid", int'(throw_valid), 0);
        checkOutput("rst_power", int'(throw_power), 0);
        checkOutput("rst_error", int'(link_error), 0);
        checkOutput("rst_state", int'(dut.state), int'(IDLE));
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Power 19 with flag held high: one pulse 18 edges after the raw edge
        applyStimulus(1'b1, 5'd19, 1'b0, 1'b0, 40);
        checkOutput("a_pulse_edge", first_pulse, 18);
        checkOutput("a_pulse_count", pulse_count, 1);
        checkOutput("a_power", int'(throw_power), 19);
        applyStimulus(1'b0, 5'd19, 1'b0, 1'b0, 25);
        checkOutput("a_release_pulses", pulse_count, 0);
        checkOutput("a_power_hold", int'(throw_power), 19);
        checkOutput("a_state_idle", int'(dut.state), int'(IDLE));

        // Power 0 is a legal throw
        applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 30);
        checkOutput("z_pulse_edge", first_pulse, 18);
        checkOutput("z_pulse_count", pulse_count, 1);
        checkOutput("z_power", int'(throw_power), 0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 25);

        // Five-cycle flag glitch is rejected
        applyStimulus(1'b1, 5'd7, 1'b0, 1'b0, 5);
        checkOutput("b_glitch_pulses", pulse_count, 0);
        applyStimulus(1'b0, 5'd7, 1'b0, 1'b0, 12);
        checkOutput("b_after_pulses", pulse_count, 0);
        checkOutput("b_state_idle", int'(dut.state), int'(IDLE));
        checkOutput("b_power_hold", int'(throw_power), 0);

        // Power toggling 3/4 every 8 cycles with flag high times out
        for (int i = 0; i < 138; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 5'd3 : 5'd4, 1'b0, 1'b0, 8);
            total_pulses += pulse_count;
        end
        checkOutput("c_timeout_pulses", total_pulses, 0);
        checkOutput("c_link_error", int'(link_error), 1);
        checkOutput("c_state_idle", int'(dut.state), int'(IDLE));
        applyStimulus(1'b0, 5'd3, 1'b0, 1'b0, 25);
        checkOutput("c_error_sticky", int'(link_error), 1);
        checkOutput("c_release_pulses", pulse_count, 0);

        // Ready line filtering: 3-cycle glitch ignored, 20-cycle level accepted
        applyStimulus(1'b0, 5'd3, 1'b1, 1'b0, 3);
        checkOutput("d_glitch_r1", first_r1, -1);
        applyStimulus(1'b0, 5'd3, 1'b0, 1'b0, 30);
        checkOutput("d_glitch_r1_after", first_r1, -1);
        applyStimulus(1'b0, 5'd3, 1'b1, 1'b0, 20);
        checkOutput("d_r1_rise_edge", first_r1, 18);
        checkOutput("d_r2_quiet", first_r2, -1);
        applyStimulus(1'b0, 5'd3, 1'b1, 1'b1, 20);
        checkOutput("d_r2_rise_edge", first_r2, 18);
        checkOutput("d_r1_hold", int'(player1_ready), 1);
        applyStimulus(1'b0, 5'd3, 1'b0, 1'b0, 20);
        checkOutput("d_r1_fall", int'(player1_ready), 0);
        checkOutput("d_r2_fall", int'(player2_ready), 0);

        // Reset mid-QUAL aborts; a flag still high is not a new edge
        applyStimulus(1'b1, 5'd11, 1'b0, 1'b0, 8);
        checkOutput("e_qual_state", int'(dut.state), int'(QUAL));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("e_rst_valid", int'(throw_valid), 0);
        checkOutput("e_rst_power", int'(throw_power), 0);
        checkOutput("e_rst_error", int'(link_error), 0);
        checkOutput("e_rst_state", int'(dut.state), int'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd11, 1'b0, 1'b0, 40);
        checkOutput("e_held_pulses", pulse_count, 0);
        checkOutput("e_held_error", int'(link_error), 0);
        applyStimulus(1'b0, 5'd11, 1'b0, 1'b0, 6);
        applyStimulus(1'b1, 5'd11, 1'b0, 1'b0, 30);
        checkOutput("e_rearm_edge", first_pulse, 18);
        checkOutput("e_rearm_count", pulse_count, 1);
        checkOutput("e_rearm_power", int'(throw_power), 11);
        applyStimulus(1'b0, 5'd11, 1'b0, 1'b0, 25);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
